// File: rtl/baby_pkg.sv
// Shared constants and types for the Manchester Baby (SSEM) core.
package baby_pkg;
    localparam int WORD_W = 32;
    localparam int ADDR_W = 5;

    localparam logic [2:0] OP_JMP  = 3'b000;
    localparam logic [2:0] OP_JRP  = 3'b001;
    localparam logic [2:0] OP_LDN  = 3'b010;
    localparam logic [2:0] OP_STO  = 3'b011;
    localparam logic [2:0] OP_SUB  = 3'b100;
    localparam logic [2:0] OP_SUB2 = 3'b101;
    localparam logic [2:0] OP_CMP  = 3'b110;
    localparam logic [2:0] OP_STP  = 3'b111;

    typedef enum logic [1:0] {INC, FETCH, EXEC, HALT} state_e;
endpackage

// File: rtl/baby_alu.sv
// Combinational execute unit: next accumulator, next control instruction, CMP skip.
module baby_alu
    import baby_pkg::*;
(
    input  logic [2:0]        op_i,
    input  logic [WORD_W-1:0] a_i,
    input  logic [WORD_W-1:0] s_i,
    input  logic [WORD_W-1:0] ci_i,
    output logic [WORD_W-1:0] next_a_o,
    output logic [WORD_W-1:0] next_ci_o,
    output logic              skip_o
);
    always_comb begin
        next_a_o  = a_i;
        next_ci_o = ci_i;
        skip_o    = 1'b0;
        case (op_i)
            OP_JMP:          next_ci_o = s_i;
            OP_JRP:          next_ci_o = ci_i + s_i;
            OP_LDN:          next_a_o  = '0 - s_i;
            OP_SUB, OP_SUB2: next_a_o  = a_i - s_i;
            OP_CMP:          skip_o    = a_i[WORD_W-1];
            default: ;
        endcase
    end
endmodule

// File: rtl/logisim_top_level_shell.sv
// SSEM core: A/CI/PI registers, INC/FETCH/EXEC sequencer and per-bit store port fan-out.
module logisim_top_level_shell
    import baby_pkg::*;
(
    input  logic fpgaGlobalClock,
    input  logic reset_i_0,
    input  logic ram_data_i_0,  ram_data_i_1,  ram_data_i_2,  ram_data_i_3,
                 ram_data_i_4,  ram_data_i_5,  ram_data_i_6,  ram_data_i_7,
                 ram_data_i_8,  ram_data_i_9,  ram_data_i_10, ram_data_i_11,
                 ram_data_i_12, ram_data_i_13, ram_data_i_14, ram_data_i_15,
                 ram_data_i_16, ram_data_i_17, ram_data_i_18, ram_data_i_19,
                 ram_data_i_20, ram_data_i_21, ram_data_i_22, ram_data_i_23,
                 ram_data_i_24, ram_data_i_25, ram_data_i_26, ram_data_i_27,
                 ram_data_i_28, ram_data_i_29, ram_data_i_30, ram_data_i_31,
    output logic ram_data_o_0,  ram_data_o_1,  ram_data_o_2,  ram_data_o_3,
                 ram_data_o_4,  ram_data_o_5,  ram_data_o_6,  ram_data_o_7,
                 ram_data_o_8,  ram_data_o_9,  ram_data_o_10, ram_data_o_11,
                 ram_data_o_12, ram_data_o_13, ram_data_o_14, ram_data_o_15,
                 ram_data_o_16, ram_data_o_17, ram_data_o_18, ram_data_o_19,
                 ram_data_o_20, ram_data_o_21, ram_data_o_22, ram_data_o_23,
                 ram_data_o_24, ram_data_o_25, ram_data_o_26, ram_data_o_27,
                 ram_data_o_28, ram_data_o_29, ram_data_o_30, ram_data_o_31,
    output logic ram_addr_o_0, ram_addr_o_1, ram_addr_o_2, ram_addr_o_3, ram_addr_o_4,
    output logic ram_rw_en_o_0,
    output logic stop_lamp_o_0,
    output logic logisim_clock_tree_0_out
);
    logic [WORD_W-1:0] rd_data;
    logic [ADDR_W-1:0] addr;
    logic              rw_en;

    state_e            state_q, state_d;
    logic [WORD_W-1:0] a_q, a_d, ci_q, ci_d;
    // Only the function and line fields of PI are ever used, so only those are held.
    logic [2:0]        op_q, op_d;
    logic [ADDR_W-1:0] pln_q, pln_d;
    logic              lamp_q, lamp_d;

    logic [WORD_W-1:0] alu_a, alu_ci;
    logic              alu_skip;

    assign rd_data = {ram_data_i_31, ram_data_i_30, ram_data_i_29, ram_data_i_28,
                      ram_data_i_27, ram_data_i_26, ram_data_i_25, ram_data_i_24,
                      ram_data_i_23, ram_data_i_22, ram_data_i_21, ram_data_i_20,
                      ram_data_i_19, ram_data_i_18, ram_data_i_17, ram_data_i_16,
                      ram_data_i_15, ram_data_i_14, ram_data_i_13, ram_data_i_12,
                      ram_data_i_11, ram_data_i_10, ram_data_i_9,  ram_data_i_8,
                      ram_data_i_7,  ram_data_i_6,  ram_data_i_5,  ram_data_i_4,
                      ram_data_i_3,  ram_data_i_2,  ram_data_i_1,  ram_data_i_0};

    assign {ram_data_o_31, ram_data_o_30, ram_data_o_29, ram_data_o_28,
            ram_data_o_27, ram_data_o_26, ram_data_o_25, ram_data_o_24,
            ram_data_o_23, ram_data_o_22, ram_data_o_21, ram_data_o_20,
            ram_data_o_19, ram_data_o_18, ram_data_o_17, ram_data_o_16,
            ram_data_o_15, ram_data_o_14, ram_data_o_13, ram_data_o_12,
            ram_data_o_11, ram_data_o_10, ram_data_o_9,  ram_data_o_8,
            ram_data_o_7,  ram_data_o_6,  ram_data_o_5,  ram_data_o_4,
            ram_data_o_3,  ram_data_o_2,  ram_data_o_1,  ram_data_o_0} = a_q;

    assign {ram_addr_o_4, ram_addr_o_3, ram_addr_o_2, ram_addr_o_1, ram_addr_o_0} = addr;
    assign ram_rw_en_o_0            = rw_en;
    assign stop_lamp_o_0            = lamp_q;
    assign logisim_clock_tree_0_out = fpgaGlobalClock;

    baby_alu u_alu (
        .op_i      (op_q),
        .a_i       (a_q),
        .s_i       (rd_data),
        .ci_i      (ci_q),
        .next_a_o  (alu_a),
        .next_ci_o (alu_ci),
        .skip_o    (alu_skip)
    );

    always_ff @(posedge fpgaGlobalClock or negedge reset_i_0) begin
        if (!reset_i_0) begin
            state_q <= INC;
            a_q     <= '0;
            ci_q    <= '0;
            op_q    <= '0;
            pln_q   <= '0;
            lamp_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            ci_q    <= ci_d;
            op_q    <= op_d;
            pln_q   <= pln_d;
            lamp_q  <= lamp_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        ci_d    = ci_q;
        op_d    = op_q;
        pln_d   = pln_q;
        lamp_d  = lamp_q;
        addr    = ci_q[ADDR_W-1:0];
        rw_en   = 1'b0;
        case (state_q)
            INC: begin
                ci_d    = ci_q + 1'b1;
                state_d = FETCH;
            end
            FETCH: begin
                op_d    = rd_data[15:13];
                pln_d   = rd_data[ADDR_W-1:0];
                state_d = EXEC;
            end
            EXEC: begin
                addr    = pln_q;
                a_d     = alu_a;
                ci_d    = alu_skip ? ci_q + 1'b1 : alu_ci;
                rw_en   = (op_q == OP_STO);
                state_d = INC;
                if (op_q == OP_STP) begin
                    state_d = HALT;
                    lamp_d  = 1'b1;
                end
            end
            HALT: addr = pln_q;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_logisim_top_level_shell.sv
// Directed program bench for the SSEM core against a 32-line combinational-read store.
module tb_logisim_top_level_shell;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] rd;
    wire  [31:0] wd;
    wire  [4:0]  addr;
    wire         rw_en, lamp, tree;
    logic [31:0] mem [32];
    int          n_chk = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    assign rd = mem[addr];
    always @(posedge clk) if (rw_en) mem[addr] <= wd;

    logisim_top_level_shell dut (
        .fpgaGlobalClock(clk), .reset_i_0(rst_n),
        .ram_data_i_0(rd[0]),   .ram_data_i_1(rd[1]),   .ram_data_i_2(rd[2]),   .ram_data_i_3(rd[3]),
        .ram_data_i_4(rd[4]),   .ram_data_i_5(rd[5]),   .ram_data_i_6(rd[6]),   .ram_data_i_7(rd[7]),
        .ram_data_i_8(rd[8]),   .ram_data_i_9(rd[9]),   .ram_data_i_10(rd[10]), .ram_data_i_11(rd[11]),
        .ram_data_i_12(rd[12]), .ram_data_i_13(rd[13]), .ram_data_i_14(rd[14]), .ram_data_i_15(rd[15]),
        .ram_data_i_16(rd[16]), .ram_data_i_17(rd[17]), .ram_data_i_18(rd[18]), .ram_data_i_19(rd[19]),
        .ram_data_i_20(rd[20]), .ram_data_i_21(rd[21]), .ram_data_i_22(rd[22]), .ram_data_i_23(rd[23]),
        .ram_data_i_24(rd[24]), .ram_data_i_25(rd[25]), .ram_data_i_26(rd[26]), .ram_data_i_27(rd[27]),
        .ram_data_i_28(rd[28]), .ram_data_i_29(rd[29]), .ram_data_i_30(rd[30]), .ram_data_i_31(rd[31]),
        .ram_data_o_0(wd[0]),   .ram_data_o_1(wd[1]),   .ram_data_o_2(wd[2]),   .ram_data_o_3(wd[3]),
        .ram_data_o_4(wd[4]),   .ram_data_o_5(wd[5]),   .ram_data_o_6(wd[6]),   .ram_data_o_7(wd[7]),
        .ram_data_o_8(wd[8]),   .ram_data_o_9(wd[9]),   .ram_data_o_10(wd[10]), .ram_data_o_11(wd[11]),
        .ram_data_o_12(wd[12]), .ram_data_o_13(wd[13]), .ram_data_o_14(wd[14]), .ram_data_o_15(wd[15]),
        .ram_data_o_16(wd[16]), .ram_data_o_17(wd[17]), .ram_data_o_18(wd[18]), .ram_data_o_19(wd[19]),
        .ram_data_o_20(wd[20]), .ram_data_o_21(wd[21]), .ram_data_o_22(wd[22]), .ram_data_o_23(wd[23]),
        .ram_data_o_24(wd[24]), .ram_data_o_25(wd[25]), .ram_data_o_26(wd[26]), .ram_data_o_27(wd[27]),
        .ram_data_o_28(wd[28]), .ram_data_o_29(wd[29]), .ram_data_o_30(wd[30]), .ram_data_o_31(wd[31]),
        .ram_addr_o_0(addr[0]), .ram_addr_o_1(addr[1]), .ram_addr_o_2(addr[2]),
        .ram_addr_o_3(addr[3]), .ram_addr_o_4(addr[4]),
        .ram_rw_en_o_0(rw_en), .stop_lamp_o_0(lamp), .logisim_clock_tree_0_out(tree)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // From INC: step to FETCH, check the fetched line, step on into EXEC.
    task automatic fetch(input logic [4:0] line);
        tick();
        chk("fetch_addr", {27'd0, addr}, {27'd0, line});
        tick();
    endtask

    task automatic load_prog();
        for (int i = 0; i < 32; i++) mem[i] = 32'h0000E000;
        mem[1]  = 32'h00004014; mem[2]  = 32'h00006015; mem[3]  = 32'h00008016;
        mem[4]  = 32'h00004014; mem[5]  = 32'h0000A016; mem[6]  = 32'h0000C000;
        mem[8]  = 32'h00004019; mem[9]  = 32'h0000C000; mem[10] = 32'h00000018;
        mem[13] = 32'h0000201A; mem[16] = 32'h0000001B; mem[31] = 32'h0000401C;
        mem[20] = 32'd5;  mem[21] = 32'd0;  mem[22] = 32'd3;  mem[24] = 32'd12;
        mem[25] = 32'hFFFFFFFF; mem[26] = 32'd2; mem[27] = 32'd30; mem[28] = 32'd7;
    endtask

    initial begin
        load_prog();
        repeat (2) tick();
        chk("rst_addr", {27'd0, addr}, 32'd0);
        chk("rst_data", wd, 32'd0);
        chk("rst_rw", {31'd0, rw_en}, 32'd0);
        chk("rst_lamp", {31'd0, lamp}, 32'd0);
        chk("clk_tree_hi", {31'd0, tree}, {31'd0, clk});
        rst_n = 1'b1;
        chk("inc_addr", {27'd0, addr}, 32'd0);

        fetch(1);  tick(); chk("ldn_a", wd, 32'hFFFFFFFB);
        fetch(2);
        chk("sto_rw", {31'd0, rw_en}, 32'd1);
        chk("sto_addr", {27'd0, addr}, 32'd21);
        chk("sto_data", wd, 32'hFFFFFFFB);
        tick();
        chk("sto_mem", mem[21], 32'hFFFFFFFB);
        chk("sto_rw_off", {31'd0, rw_en}, 32'd0);
        fetch(3);  tick(); chk("sub_a", wd, 32'hFFFFFFF8);
        fetch(4);  tick(); chk("ldn2_a", wd, 32'hFFFFFFFB);
        fetch(5);  tick(); chk("sub101_a", wd, 32'hFFFFFFF8);
        fetch(6);  tick();
        fetch(8);  tick(); chk("ldn_neg1_a", wd, 32'd1);
        fetch(9);  tick();
        fetch(10); tick();
        fetch(13); tick();
        fetch(16); tick();
        fetch(31); tick(); chk("line31_a", wd, 32'hFFFFFFF9);
        fetch(0);
        chk("pre_stp_lamp", {31'd0, lamp}, 32'd0);
        chk("stp_rw", {31'd0, rw_en}, 32'd0);
        tick();
        chk("halt_lamp", {31'd0, lamp}, 32'd1);
        for (int i = 0; i < 100; i++) begin
            tick();
            chk("halt_lamp_hold", {31'd0, lamp}, 32'd1);
            chk("halt_rw", {31'd0, rw_en}, 32'd0);
            chk("halt_a", wd, 32'hFFFFFFF9);
            chk("halt_addr", {27'd0, addr}, 32'd0);
        end
        #4;
        chk("clk_tree_lo", {31'd0, tree}, {31'd0, clk});

        rst_n = 1'b0;
        #1;
        chk("rst2_lamp", {31'd0, lamp}, 32'd0);
        chk("rst2_addr", {27'd0, addr}, 32'd0);
        chk("rst2_data", wd, 32'd0);

        mem[21] = 32'd0;
        tick();
        rst_n = 1'b1;
        fetch(1); tick();
        fetch(2);
        chk("sto2_rw", {31'd0, rw_en}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_rw", {31'd0, rw_en}, 32'd0);
        chk("abort_addr", {27'd0, addr}, 32'd0);
        tick();
        chk("abort_mem", mem[21], 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
